design_select_ctrl: RTL and testbench

// - Drives the 4-bit design_select bus and a global active-low design hold into the user-project design mux.
// - The host requests a design number over a req/ack handshake.
// - Switching is sequenced: gpio outputs are quiesced, all designs are held in reset, select is updated, then reset is released.
// - The sequence prevents glitching pads and half-reset designs during a change of design.

---
 rtl/design_select_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_design_select_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/design_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : design_select_ctrl
// Description : Sequenced design-select controller for the user-project
//               design mux. A host asks for a design number over a req/ack
//               handshake. Each real switch runs the same steps in order:
//               quiesce the gpio pads, hold every design in reset, change
//               the select, release the hold, then restore the pads.
//               Optional feature macro: DESIGN_WDT_EN. When it is defined, a
//               heartbeat watchdog reverts the select to 0 if the selected
//               design stops kicking.
// Ports       : clk             - system clock
//               n_rst           - asynchronous active-low reset
//               sel_req         - host request, held until sel_ack
//               sel_value[3:0]  - requested design number
//               sel_ack         - one-cycle completion/reject pulse
//               sel_err         - with sel_ack: 1 = rejected (> MAX_DESIGN)
//               busy            - high whenever the FSM is not IDLE
//               design_select   - registered select to the design mux
//               designs_hold_n  - active-low global design hold
//               gpio_force_in_n - low = mux forces pads to safe input state
//               wdt_kick        - heartbeat from the selected design
//               wdt_fired       - sticky watchdog-revert flag
// Revision    : 1.0 - initial release
// ============================================================================
module design_select_ctrl #(
    parameter int QUIESCE_CYCLES = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int MAX_DESIGN     = 12,
    parameter int WDT_CYCLES     = 2**20
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       sel_req,
    input  logic [3:0] sel_value,
    output logic       sel_ack,
    output logic       sel_err,
    output logic       busy,
    output logic [3:0] design_select,
    output logic       designs_hold_n,
    output logic       gpio_force_in_n,
    input  logic       wdt_kick,
    output logic       wdt_fired
);

    localparam logic [2:0] C_BOOT    = 3'd0;
    localparam logic [2:0] C_IDLE    = 3'd1;
    localparam logic [2:0] C_QUIESCE = 3'd2;
    localparam logic [2:0] C_HOLD    = 3'd3;
    localparam logic [2:0] C_RELEASE = 3'd4;
    localparam logic [2:0] C_ACK     = 3'd5;

    localparam int C_CNT_MAX = (QUIESCE_CYCLES > HOLD_CYCLES) ? QUIESCE_CYCLES : HOLD_CYCLES;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

    // Counters run down from (length - 1) to 0, so the state lasts exactly
    // "length" cycles.
    localparam logic [C_CNT_W-1:0] C_Q_LOAD = C_CNT_W'(QUIESCE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_H_LOAD = C_CNT_W'(HOLD_CYCLES - 1);

    logic [2:0]         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [3:0]         r_target;
    logic [3:0]         r_design_select;
    logic               r_hold_n;
    logic               r_force_n;
    logic               r_busy;
    logic               r_sel_ack;
    logic               r_sel_err;

    logic               w_reject;
    logic               w_same;
    logic               w_host_switch;
    logic               w_wdt_timeout;
    logic               w_wdt_run;

    assign w_reject      = int'(sel_value) > MAX_DESIGN;
    assign w_same        = (sel_value == r_design_select);
    assign w_host_switch = sel_req && !w_reject && !w_same;

    // ------------------------------------------------------------------------
    // Main sequencer. All outputs are registered and updated on the same edge
    // as the state change that owns them.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= C_BOOT;
            r_cnt           <= C_H_LOAD;
            r_target        <= 4'd0;
            r_design_select <= 4'd0;
            r_hold_n        <= 1'b0;
            r_force_n       <= 1'b0;
            r_busy          <= 1'b1;
            r_sel_ack       <= 1'b0;
            r_sel_err       <= 1'b0;
        end else begin
            // Ack/err are single-cycle: only a transition into ACK raises them.
            r_sel_ack <= 1'b0;
            r_sel_err <= 1'b0;
            case (r_state)
                C_BOOT: begin
                    if (r_cnt == '0) begin
                        r_state   <= C_IDLE;
                        r_hold_n  <= 1'b1;
                        r_force_n <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                C_IDLE: begin
                    // A host request takes priority over a watchdog timeout.
                    if (sel_req) begin
                        r_target <= sel_value;
                        r_busy   <= 1'b1;
                        if (w_reject) begin
                            r_state   <= C_ACK;
                            r_sel_ack <= 1'b1;
                            r_sel_err <= 1'b1;
                        end else if (w_same) begin
                            r_state   <= C_ACK;
                            r_sel_ack <= 1'b1;
                        end else begin
                            r_state   <= C_QUIESCE;
                            r_cnt     <= C_Q_LOAD;
                            r_force_n <= 1'b0;
                        end
                    end else if (w_wdt_timeout) begin
                        r_target  <= 4'd0;
                        r_busy    <= 1'b1;
                        r_state   <= C_QUIESCE;
                        r_cnt     <= C_Q_LOAD;
                        r_force_n <= 1'b0;
                    end
                end
                C_QUIESCE: begin
                    if (r_cnt == '0) begin
                        r_state  <= C_HOLD;
                        r_cnt    <= C_H_LOAD;
                        r_hold_n <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                C_HOLD: begin
                    // Updating at the end of the first HOLD cycle means the
                    // select moves strictly after hold and force are low.
                    if (r_cnt == C_H_LOAD) begin
                        r_design_select <= r_target;
                    end
                    if (r_cnt == '0) begin
                        r_state  <= C_RELEASE;
                        r_hold_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                C_RELEASE: begin
                    r_force_n <= 1'b1;
                    if (w_wdt_run) begin
                        // Watchdog-initiated revert: nobody is waiting for an ack.
                        r_state <= C_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state   <= C_ACK;
                        r_sel_ack <= 1'b1;
                    end
                end
                C_ACK: begin
                    r_state <= C_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= C_BOOT;
                    r_cnt     <= C_H_LOAD;
                    r_hold_n  <= 1'b0;
                    r_force_n <= 1'b0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

`ifdef DESIGN_WDT_EN
    // ------------------------------------------------------------------------
    // Heartbeat watchdog. Counting only happens while a real design is
    // selected and the sequencer is idle, so switches never trip it.
    // ------------------------------------------------------------------------
    localparam int                 C_WDT_W     = $clog2(WDT_CYCLES + 1);
    localparam logic [C_WDT_W-1:0] C_WDT_LIMIT = C_WDT_W'(WDT_CYCLES);

    logic [C_WDT_W-1:0] r_wdt_cnt;
    logic               r_wdt_run;
    logic               r_wdt_fired;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wdt_cnt <= '0;
        end else if (wdt_kick || (r_design_select == 4'd0) || r_busy) begin
            r_wdt_cnt <= '0;
        end else if (r_wdt_cnt != C_WDT_LIMIT) begin
            r_wdt_cnt <= r_wdt_cnt + 1'b1;
        end
    end

    // r_wdt_run marks a sequence started by the watchdog so RELEASE skips
    // the ack; r_wdt_fired is set when that sequence completes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wdt_run   <= 1'b0;
            r_wdt_fired <= 1'b0;
        end else if (r_state == C_IDLE) begin
            if (w_host_switch) begin
                r_wdt_fired <= 1'b0;
            end else if (!sel_req && w_wdt_timeout) begin
                r_wdt_run <= 1'b1;
            end
        end else if ((r_state == C_RELEASE) && r_wdt_run) begin
            r_wdt_run   <= 1'b0;
            r_wdt_fired <= 1'b1;
        end
    end

    assign w_wdt_timeout = (r_wdt_cnt == C_WDT_LIMIT);
    assign w_wdt_run     = r_wdt_run;
    assign wdt_fired     = r_wdt_fired;
`else
    // Without the watchdog the kick input and timeout parameter have no load.
    logic w_unused_wdt;
    assign w_unused_wdt  = wdt_kick ^ (WDT_CYCLES == 0);
    assign w_wdt_timeout = 1'b0;
    assign w_wdt_run     = 1'b0;
    assign wdt_fired     = 1'b0;
`endif

    assign sel_ack         = r_sel_ack;
    assign sel_err         = r_sel_err;
    assign busy            = r_busy;
    assign design_select   = r_design_select;
    assign designs_hold_n  = r_hold_n;
    assign gpio_force_in_n = r_force_n;

endmodule
`default_nettype wire

// File: tb/tb_design_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_design_select_ctrl
// Description : Self-checking bench for design_select_ctrl. A small model
//               tracks the current design and derives the expected ack
//               latency and error flag for every request from the
//               handshake rules. Watchdog scenarios build only when
//               DESIGN_WDT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_design_select_ctrl;

    localparam int Q    = 4;
    localparam int H    = 8;
    localparam int MAXD = 12;
    localparam int WDT  = 16;

    logic       clk       = 1'b0;
    logic       n_rst     = 1'b0;
    logic       sel_req   = 1'b0;
    logic [3:0] sel_value = 4'd0;
    logic       wdt_kick  = 1'b0;
    logic       sel_ack;
    logic       sel_err;
    logic       busy;
    logic [3:0] design_select;
    logic       designs_hold_n;
    logic       gpio_force_in_n;
    logic       wdt_fired;

    design_select_ctrl #(
        .QUIESCE_CYCLES (Q),
        .HOLD_CYCLES    (H),
        .MAX_DESIGN     (MAXD),
        .WDT_CYCLES     (WDT)
    ) u_dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .sel_req         (sel_req),
        .sel_value       (sel_value),
        .sel_ack         (sel_ack),
        .sel_err         (sel_err),
        .busy            (busy),
        .design_select   (design_select),
        .designs_hold_n  (designs_hold_n),
        .gpio_force_in_n (gpio_force_in_n),
        .wdt_kick        (wdt_kick),
        .wdt_fired       (wdt_fired)
    );

    always #5 clk = ~clk;

    int passes  = 0;
    int total   = 0;
    int cur_sel = 0;   // model: design the mux should currently select

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it to its ack, checking latency, result
    // and the pad/hold ordering on every cycle.
    task automatic do_request(input int v);
        int         k;
        int         exp_lat;
        bit         seen;
        bit         order_ok;
        bit         quiet;
        bit         is_err;
        bit         is_same;
        logic [3:0] prev;
        is_err   = (v > MAXD);
        is_same  = !is_err && (v == cur_sel);
        exp_lat  = (is_err || is_same) ? 2 : (1 + Q + H + 2);
        sel_req   = 1'b1;
        sel_value = 4'(v);
        prev      = design_select;
        seen      = 1'b0;
        order_ok  = 1'b1;
        quiet     = 1'b1;
        k         = 0;
        while (!seen && k < 40) begin
            tick();
            k++;
            if ((design_select !== prev) && !((designs_hold_n === 1'b0) && (gpio_force_in_n === 1'b0)))
                order_ok = 1'b0;
            prev = design_select;
            if ((designs_hold_n !== 1'b1) || (gpio_force_in_n !== 1'b1))
                quiet = 1'b0;
            if (sel_ack === 1'b1)
                seen = 1'b1;
        end
        check("ack_seen", 32'(seen), 32'd1);
        check("ack_latency", 32'(k + 1), 32'(exp_lat));
        check("sel_err", 32'(sel_err), 32'(is_err));
        if (!is_err)
            cur_sel = v;
        check("design_select", 32'(design_select), 32'(cur_sel));
        check("ordering", 32'(order_ok), 32'd1);
        check("force_at_ack", 32'(gpio_force_in_n), 32'd1);
        check("hold_at_ack", 32'(designs_hold_n), 32'd1);
        if (is_err || is_same)
            check("no_activity", 32'(quiet), 32'd1);
        sel_req = 1'b0;
        tick();
        check("ack_pulse", 32'(sel_ack), 32'd0);
        check("err_idle", 32'(sel_err), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int v;
        int k;
        int acks;
        bit order_ok;
        logic [3:0] prev;

        // ---------------- reset and boot ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_select", 32'(design_select), 32'd0);
        check("rst_hold", 32'(designs_hold_n), 32'd0);
        check("rst_force", 32'(gpio_force_in_n), 32'd0);
        check("rst_ack", 32'(sel_ack), 32'd0);
        check("rst_err", 32'(sel_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_fired", 32'(wdt_fired), 32'd0);
        #2 n_rst = 1'b1;
        tick();
        check("boot_busy", 32'(busy), 32'd1);
        check("boot_hold", 32'(designs_hold_n), 32'd0);
        repeat (H) tick();
        check("boot_done_hold", 32'(designs_hold_n), 32'd1);
        check("boot_done_force", 32'(gpio_force_in_n), 32'd1);
        check("boot_done_busy", 32'(busy), 32'd0);
        check("boot_done_select", 32'(design_select), 32'd0);

        // ---------------- directed requests ----------------
        do_request(5);
        do_request(13);
        do_request(5);
        do_request(0);
        do_request(15);
        do_request(12);

        // ---------------- randomized requests ----------------
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0)
                v = cur_sel;
            else
                v = int'($urandom_range(0, 15));
            do_request(v);
            repeat ($urandom_range(0, 3)) tick();
        end

        // ---------------- reset during HOLD of a 3->7 switch ----------------
        do_request(3);
        sel_req   = 1'b1;
        sel_value = 4'd7;
        repeat (1 + Q + 3) tick();
        check("mid_hold_low", 32'(designs_hold_n), 32'd0);
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_select", 32'(design_select), 32'd0);
        check("mid_rst_hold", 32'(designs_hold_n), 32'd0);
        check("mid_rst_force", 32'(gpio_force_in_n), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_ack", 32'(sel_ack), 32'd0);
        sel_req = 1'b0;
        cur_sel = 0;
        #1 n_rst = 1'b1;
        acks = 0;
        for (int i = 0; i < H + 3; i++) begin
            tick();
            if (sel_ack === 1'b1)
                acks++;
        end
        check("mid_rst_no_ack", 32'(acks), 32'd0);
        check("reboot_busy", 32'(busy), 32'd0);
        check("reboot_hold", 32'(designs_hold_n), 32'd1);
        check("reboot_select", 32'(design_select), 32'd0);
        do_request(7);

`ifdef DESIGN_WDT_EN
        // ---------------- watchdog revert without kicks ----------------
        do_request(2);
        acks     = 0;
        k        = 0;
        order_ok = 1'b1;
        prev     = design_select;
        while ((wdt_fired !== 1'b1) && k < 200) begin
            tick();
            k++;
            if (sel_ack === 1'b1)
                acks++;
            if ((design_select !== prev) && !((designs_hold_n === 1'b0) && (gpio_force_in_n === 1'b0)))
                order_ok = 1'b0;
            prev = design_select;
        end
        // Timeout needs WDT idle cycles before the revert sequence starts.
        check("wdt_not_early", 32'(k > WDT), 32'd1);
        check("wdt_fired", 32'(wdt_fired), 32'd1);
        check("wdt_select", 32'(design_select), 32'd0);
        check("wdt_no_ack", 32'(acks), 32'd0);
        check("wdt_ordering", 32'(order_ok), 32'd1);
        cur_sel = 0;
        tick();
        check("wdt_idle", 32'(busy), 32'd0);
        check("wdt_sticky", 32'(wdt_fired), 32'd1);

        // A new accepted switch clears the flag; kicks keep the design alive.
        do_request(2);
        check("wdt_cleared", 32'(wdt_fired), 32'd0);
        for (int i = 0; i < 100; i++) begin
            wdt_kick = (i % 10 == 0);
            tick();
        end
        wdt_kick = 1'b0;
        check("kick_select", 32'(design_select), 32'd2);
        check("kick_fired", 32'(wdt_fired), 32'd0);
`else
        do_request(2);
        repeat (40) tick();
        check("nowdt_select", 32'(design_select), 32'd2);
        check("nowdt_fired", 32'(wdt_fired), 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
